pef_array: RTL and testbench

Multi-channel phase/edge front-end for the oscillatory neuron control path. It synchronises N_CH asynchronous oscillator bitstreams and detects their rising edges. Each edge is time-stamped against channel 0, the reference oscillator, which yields a per-channel phase in clock cycles plus the reference period. Results go to the downstream coupling/readout logic one at a time over a valid/ready stream. This replaces the single-channel edge-finder with a generalised, parametrised, buffered version.

---
 rtl/pef_array.sv | 145 ++++++++++++++
 tb/tb_pef_array.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pef_array.sv
// pef_array: synchronises N_CH oscillator bitstreams, detects rising edges and
// streams each channel's phase (cycles after the last channel-0 edge) over valid/ready.
module pef_array #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             re_n,
  input  logic             en,
  input  logic [N_CH-1:0]  n,
  output logic [N_CH-1:0]  edges,  // named edges because "edge" is a reserved word
  output logic [CNT_W-1:0] phase,
  output logic [CH_W-1:0]  phase_ch,
  output logic             phase_valid,
  input  logic             phase_ready,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic [N_CH-1:0]  ovf,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_reg;
  logic [N_CH-1:0]  prev_reg, edge_reg;
  logic [CNT_W-1:0] cnt_reg, period_reg, cap_val;
  logic             locked_reg;
  logic [N_CH-1:0]  take, hit, pend_reg, pend_next, ovf_reg, ovf_next;
  logic [CNT_W-1:0] cap_reg  [N_CH];
  logic [CNT_W-1:0] cap_next [N_CH];
  logic [CNT_W-1:0] phase_reg;
  logic [CH_W-1:0]  phase_ch_reg, rr_ptr_reg, sel_idx;
  logic             valid_reg, sel_found, out_load, do_load;
  logic [2*N_CH-1:0] rot;
  logic [CH_W:0]    sel_off, sel_sum;

  // Input synchroniser plus one extra flop to look for the 0->1 transition
  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      sync_reg <= '0;
      prev_reg <= '0;
      edge_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], n};
      prev_reg <= sync_reg[SYNC_STAGES-1];
      edge_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      cnt_reg    <= '0;
      period_reg <= '0;
      locked_reg <= 1'b0;
    end else if (en) begin
      if (edge_reg[0]) begin
        cnt_reg    <= '0;
        period_reg <= (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
        locked_reg <= 1'b1;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      locked_reg <= 1'b0;
    end
  end

  assign take    = edge_reg & {N_CH{en & locked_reg}};
  assign cap_val = edge_reg[0] ? '0 : cnt_reg;

  // Round-robin pick: rotate pending bits so rr_ptr lands at bit 0
  assign rot = {pend_reg, pend_reg} >> rr_ptr_reg;

  always_comb begin
    sel_found = 1'b0;
    sel_off   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!sel_found && rot[k]) begin
        sel_found = 1'b1;
        sel_off   = (CH_W+1)'(k);
      end
    end
    sel_sum = {1'b0, rr_ptr_reg} + sel_off;
    if (sel_sum >= (CH_W+1)'(N_CH)) begin
      sel_sum = sel_sum - (CH_W+1)'(N_CH);
    end
    sel_idx = sel_sum[CH_W-1:0];
  end

  assign out_load = ~valid_reg | phase_ready;
  assign do_load  = out_load & sel_found;

  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      phase_reg    <= '0;
      phase_ch_reg <= '0;
      valid_reg    <= 1'b0;
      rr_ptr_reg   <= '0;
    end else if (out_load) begin
      if (sel_found) begin
        phase_reg    <= cap_reg[sel_idx];
        phase_ch_reg <= sel_idx;
        valid_reg    <= 1'b1;
        rr_ptr_reg   <= (sel_idx == CH_W'(N_CH-1)) ? '0 : sel_idx + 1'b1;
      end else begin
        valid_reg <= 1'b0;
      end
    end
  end

  // A capture landing on the channel being unloaded refills the slot without overflow
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign hit[gi]       = do_load && (sel_idx == CH_W'(gi));
    assign pend_next[gi] = take[gi] | (pend_reg[gi] & ~hit[gi]);
    assign ovf_next[gi]  = (take[gi] & pend_reg[gi] & ~hit[gi]) | (ovf_reg[gi] & ~ovf_clr);
    assign cap_next[gi]  = take[gi] ? cap_val : cap_reg[gi];
  end

  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      pend_reg <= '0;
      ovf_reg  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        cap_reg[k] <= '0;
      end
    end else begin
      pend_reg <= pend_next;
      ovf_reg  <= ovf_next;
      for (int k = 0; k < N_CH; k++) begin
        cap_reg[k] <= cap_next[k];
      end
    end
  end

  assign edges       = edge_reg;
  assign phase       = phase_reg;
  assign phase_ch    = phase_ch_reg;
  assign phase_valid = valid_reg;
  assign period      = period_reg;
  assign locked      = locked_reg;
  assign ovf         = ovf_reg;

endmodule

// File: tb/tb_pef_array.sv
// Testbench for pef_array: timestamp-based reference model, directed scenarios
// followed by randomized traffic; outputs compared every cycle on the falling edge.
module tb_pef_array;

  localparam int N = 4, W = 8, MAXV = 255;

  logic         clk = 1'b0, re_n = 1'b0, en = 1'b0, phase_ready = 1'b0, ovf_clr = 1'b0;
  logic [N-1:0] n = '0;
  logic [N-1:0] edges, ovf;
  logic [W-1:0] phase, period;
  logic [1:0]   phase_ch;
  logic         phase_valid, locked;

  int n_checks = 0, n_pass = 0;
  int last_phase [N];

  always #5 clk = ~clk;

  pef_array #(.N_CH(N), .CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .re_n(re_n), .en(en), .n(n), .edges(edges), .phase(phase),
    .phase_ch(phase_ch), .phase_valid(phase_valid), .phase_ready(phase_ready),
    .period(period), .locked(locked), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the phase counter is expressed as enabled-cycle timestamps
  logic [N-1:0] samp_q [$];
  logic [N-1:0] m_edge = '0, m_ovf = '0, oset;
  bit           m_pend [N];
  int           m_cap  [N];
  int           m_rr, m_phase, m_ch, m_period, cur, val, sel;
  bit           m_valid, m_locked;
  longint       en_idx, ref_idx;

  function automatic void model_reset();
    samp_q = {};
    for (int i = 0; i < 3; i++) samp_q.push_back('0);
    m_edge = '0; m_ovf = '0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_cap[i] = 0; end
    m_rr = 0; m_phase = 0; m_ch = 0; m_period = 0;
    m_valid = 0; m_locked = 0;
    en_idx = 0; ref_idx = -1;
  endfunction

  always @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      model_reset();
    end else begin
      cur = (en_idx - ref_idx - 1 > MAXV) ? MAXV : int'(en_idx - ref_idx - 1);
      val = m_edge[0] ? 0 : cur;
      // output drains first, then this cycle's captures land
      sel = -1;
      if (!m_valid || phase_ready) begin
        for (int k = 0; k < N; k++) if (sel < 0 && m_pend[(m_rr + k) % N]) sel = (m_rr + k) % N;
        m_valid = (sel >= 0);
        if (sel >= 0) begin
          m_phase = m_cap[sel]; m_ch = sel; m_rr = (sel + 1) % N; m_pend[sel] = 0;
        end
      end
      oset = '0;
      for (int i = 0; i < N; i++) begin
        if (m_edge[i] && en && m_locked) begin
          oset[i] = m_pend[i]; m_pend[i] = 1; m_cap[i] = val;
        end
      end
      m_ovf = (m_ovf & ~{N{ovf_clr}}) | oset;
      if (en) begin
        if (m_edge[0]) begin
          m_period = (cur + 1 > MAXV) ? MAXV : cur + 1;
          ref_idx = en_idx; m_locked = 1;
        end
        en_idx++;
      end else begin
        m_locked = 0;
      end
      samp_q.push_back(n);
      m_edge = samp_q[1] & ~samp_q[0];
      void'(samp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("edges", 32'(edges), 32'(m_edge));
    chk("phase_valid", 32'(phase_valid), 32'(m_valid));
    if (m_valid) begin
      chk("phase", 32'(phase), 32'(m_phase));
      chk("phase_ch", 32'(phase_ch), 32'(m_ch));
    end
    chk("period", 32'(period), 32'(m_period));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (re_n && phase_valid && phase_ready) begin
      $display("xfer ch=%0d phase=%0d period=%0d t=%0t", phase_ch, phase, period, $time);
      last_phase[phase_ch] = int'(phase);
    end
  end

  initial begin
    for (int i = 0; i < N; i++) last_phase[i] = -1;

    // reset held with random inputs
    repeat (6) begin step(); n = N'($urandom); end
    chk("rst_outputs", 32'({edges, phase_valid, locked, ovf, period, phase, phase_ch}), 32'd0);
    re_n = 1'b1; n = '0;
    repeat (4) step();
    chk("locked_after_release", 32'(locked), 32'd0);
    chk("valid_after_release", 32'(phase_valid), 32'd0);

    // reference square wave (period 20) with ch1 lagging by 5 cycles
    en = 1'b1; phase_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      n[0] = ((t % 20) < 10);
      n[1] = (((t + 15) % 20) < 10);
      n[3:2] = '0;
      step();
    end
    chk("period_20", 32'(period), 32'd20);
    chk("locked_running", 32'(locked), 32'd1);

    // simultaneous rising edges on ch1 and ch3
    n = '0; repeat (5) step();
    n[1] = 1'b1; n[3] = 1'b1; repeat (8) step();
    n = '0; repeat (4) step();

    // consumer stalled: second ch2 capture overwrites the first
    phase_ready = 1'b0;
    for (int t = 0; t < 80; t++) begin
      n[0] = ((t % 20) < 10);
      n[2] = (t == 40 || t == 46);
      step();
    end
    chk("ovf2_set", 32'(ovf[2]), 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf2_clr", 32'(ovf[2]), 32'd0);
    phase_ready = 1'b1; n = '0;
    repeat (10) step();

    // randomized traffic with an enable drop and random enable blips
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) n[i] = ~n[i];
      phase_ready = ($urandom_range(9) < 7);
      ovf_clr = ($urandom_range(29) == 0);
      if (t == 710) chk("locked_en_low", 32'(locked), 32'd0);
      en = (t < 700 || t >= 710) && (t < 1000 || $urandom_range(19) != 0);
      step();
    end

    // saturation: long reference gap with a ch1 edge inside it
    ovf_clr = 1'b0; en = 1'b1; phase_ready = 1'b1; n = '0;
    last_phase[1] = -1;
    repeat (6) step();
    n[0] = 1'b1; repeat (3) step(); n[0] = 1'b0;
    for (int t = 0; t < 300; t++) begin
      n[1] = (t == 290);
      step();
    end
    n[0] = 1'b1; repeat (8) step();
    chk("sat_period", 32'(period), 32'd255);
    chk("sat_phase", 32'(last_phase[1]), 32'd255);

    // asynchronous reset while a result is held
    phase_ready = 1'b0; n = '0;
    begin
      bit got = 0;
      for (int t = 0; t < 60 && !got; t++) begin
        n[0] = ((t % 20) < 10);
        step();
        if (phase_valid) got = 1;
      end
    end
    chk("wait_valid", 32'(phase_valid), 32'd1);
    @(posedge clk); #3;
    re_n = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({edges, phase_valid, locked, ovf, period, phase, phase_ch}), 32'd0);
    repeat (3) step();
    re_n = 1'b1;
    repeat (3) step();
    chk("valid_after_rst", 32'(phase_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
